cash_dispenser: RTL and testbench

Note-dispensing engine on the receiving end of the withdraw path: it accepts an approved withdraw amount from the ATM control logic and turns it into physical note-eject pulses. It plans a greedy note mix (500/200/100) limited by per-cassette stock, then pulses one eject line per note at a fixed pace. It keeps the cassette stock counters and reports done or error.

---
 rtl/cash_dispenser.sv | 189 ++++++++++++++++++
 tb/tb_cash_dispenser.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cash_dispenser.sv
// Greedy 500/200/100 note planner and paced ejector; plan takes N+4 cycles, notes are NOTE_GAP apart.
// Backpressure: req_ready is high only in IDLE without refill; an accepted request runs to done or error.
module cash_dispenser #(
    parameter int B_WIDTH   = 20,
    parameter int CNT_WIDTH = 10,
    parameter int NOTE_GAP  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic [B_WIDTH-1:0]   req_amount,
    output logic                 req_ready,
    input  logic                 refill,
    input  logic [CNT_WIDTH-1:0] refill_500,
    input  logic [CNT_WIDTH-1:0] refill_200,
    input  logic [CNT_WIDTH-1:0] refill_100,
    output logic                 note_500,
    output logic                 note_200,
    output logic                 note_100,
    output logic                 dispense_done,
    output logic                 dispense_error,
    output logic [CNT_WIDTH-1:0] stock_500,
    output logic [CNT_WIDTH-1:0] stock_200,
    output logic [CNT_WIDTH-1:0] stock_100
);

    localparam int GAP_W = (NOTE_GAP > 1) ? $clog2(NOTE_GAP) : 1;
    localparam logic [GAP_W-1:0]     GAP_LOAD = GAP_W'(NOTE_GAP - 1);
    localparam logic [B_WIDTH-1:0]   V500     = B_WIDTH'(500);
    localparam logic [B_WIDTH-1:0]   V200     = B_WIDTH'(200);
    localparam logic [B_WIDTH-1:0]   V100     = B_WIDTH'(100);
    localparam logic [CNT_WIDTH-1:0] C_ONE    = CNT_WIDTH'(1);

    typedef enum logic [2:0] {IDLE, P500, P200, P100, CHECK, DISPENSE} state_t;

    state_t               state_q, state_d;
    logic [B_WIDTH-1:0]   rem_q, rem_d;
    logic [CNT_WIDTH-1:0] n500_q, n500_d, n200_q, n200_d, n100_q, n100_d;
    logic [CNT_WIDTH-1:0] stk500_q, stk500_d, stk200_q, stk200_d, stk100_q, stk100_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic                 note500_q, note500_d, note200_q, note200_d, note100_q, note100_d;
    logic                 done_q, done_d, err_q, err_d;
    logic                 launch;
    logic                 plan_nz;

    assign plan_nz = (n500_q != '0) || (n200_q != '0) || (n100_q != '0);

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        n500_d    = n500_q;
        n200_d    = n200_q;
        n100_d    = n100_q;
        stk500_d  = stk500_q;
        stk200_d  = stk200_q;
        stk100_d  = stk100_q;
        gap_d     = gap_q;
        note500_d = 1'b0;
        note200_d = 1'b0;
        note100_d = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        launch    = 1'b0;

        case (state_q)
            IDLE: begin
                if (refill) begin
                    stk500_d = refill_500;
                    stk200_d = refill_200;
                    stk100_d = refill_100;
                end else if (req_valid) begin
                    rem_d   = req_amount;
                    n500_d  = '0;
                    n200_d  = '0;
                    n100_d  = '0;
                    state_d = P500;
                end
            end
            P500: begin
                if (rem_q >= V500 && n500_q < stk500_q) begin
                    rem_d  = rem_q - V500;
                    n500_d = n500_q + C_ONE;
                end else begin
                    state_d = P200;
                end
            end
            P200: begin
                if (rem_q >= V200 && n200_q < stk200_q) begin
                    rem_d  = rem_q - V200;
                    n200_d = n200_q + C_ONE;
                end else begin
                    state_d = P100;
                end
            end
            P100: begin
                if (rem_q >= V100 && n100_q < stk100_q) begin
                    rem_d  = rem_q - V100;
                    n100_d = n100_q + C_ONE;
                end else begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (rem_q == '0 && plan_nz) begin
                    state_d = DISPENSE;
                    launch  = 1'b1;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            DISPENSE: begin
                // gap_q reaching zero marks the last cycle of the current slot
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else if (plan_nz) begin
                    launch = 1'b1;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Planned counts double as the remaining-note counters while ejecting.
        if (launch) begin
            gap_d = GAP_LOAD;
            if (n500_q != '0) begin
                note500_d = 1'b1;
                n500_d    = n500_q - C_ONE;
                stk500_d  = stk500_q - C_ONE;
            end else if (n200_q != '0) begin
                note200_d = 1'b1;
                n200_d    = n200_q - C_ONE;
                stk200_d  = stk200_q - C_ONE;
            end else begin
                note100_d = 1'b1;
                n100_d    = n100_q - C_ONE;
                stk100_d  = stk100_q - C_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            n500_q    <= '0;
            n200_q    <= '0;
            n100_q    <= '0;
            stk500_q  <= '0;
            stk200_q  <= '0;
            stk100_q  <= '0;
            gap_q     <= '0;
            note500_q <= 1'b0;
            note200_q <= 1'b0;
            note100_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            n500_q    <= n500_d;
            n200_q    <= n200_d;
            n100_q    <= n100_d;
            stk500_q  <= stk500_d;
            stk200_q  <= stk200_d;
            stk100_q  <= stk100_d;
            gap_q     <= gap_d;
            note500_q <= note500_d;
            note200_q <= note200_d;
            note100_q <= note100_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign req_ready      = (state_q == IDLE) && !refill;
    assign note_500       = note500_q;
    assign note_200       = note200_q;
    assign note_100       = note100_q;
    assign dispense_done  = done_q;
    assign dispense_error = err_q;
    assign stock_500      = stk500_q;
    assign stock_200      = stk200_q;
    assign stock_100      = stk100_q;

endmodule

// File: tb/tb_cash_dispenser.sv
// Directed bench for cash_dispenser: event cycles are logged at the falling edge and compared to hand-derived times.
module tb_cash_dispenser;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic [19:0] req_amount = '0;
    logic       req_ready;
    logic       refill = 1'b0;
    logic [9:0] refill_500 = '0, refill_200 = '0, refill_100 = '0;
    logic       note_500, note_200, note_100, dispense_done, dispense_error;
    logic [9:0] stock_500, stock_200, stock_100;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int q500[$], q200[$], q100[$], qdone[$], qerr[$];
    int s500_at_pulse = -1;
    int rdy_at_end = -1;

    cash_dispenser #(.B_WIDTH(20), .CNT_WIDTH(10), .NOTE_GAP(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_amount(req_amount), .req_ready(req_ready),
        .refill(refill), .refill_500(refill_500), .refill_200(refill_200), .refill_100(refill_100),
        .note_500(note_500), .note_200(note_200), .note_100(note_100),
        .dispense_done(dispense_done), .dispense_error(dispense_error),
        .stock_500(stock_500), .stock_200(stock_200), .stock_100(stock_100)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (note_500) begin q500.push_back(cyc); s500_at_pulse = int'(stock_500); end
        if (note_200) q200.push_back(cyc);
        if (note_100) q100.push_back(cyc);
        if (dispense_done) begin qdone.push_back(cyc); rdy_at_end = int'(req_ready); end
        if (dispense_error) begin qerr.push_back(cyc); rdy_at_end = int'(req_ready); end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        q500.delete(); q200.delete(); q100.delete(); qdone.delete(); qerr.delete();
        s500_at_pulse = -1;
        rdy_at_end = -1;
    endtask

    task automatic do_refill(input int a, input int b, input int c);
        @(negedge clk);
        refill = 1'b1;
        refill_500 = 10'(a); refill_200 = 10'(b); refill_100 = 10'(c);
        @(posedge clk);
        #1 refill = 1'b0;
    endtask

    task automatic do_req(input int amount, output int t);
        clear_log();
        @(negedge clk);
        req_valid = 1'b1;
        req_amount = 20'(amount);
        #1 chk("ready_at_req", req_ready, 1);
        t = cyc;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (qdone.size() + qerr.size() == 0 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, "_timeout"}, (n >= 200) ? 1 : 0, 0);
    endtask

    task automatic chk_stock(input string tag, input int a, input int b, input int c);
        chk({tag, "_s500"}, stock_500, a);
        chk({tag, "_s200"}, stock_200, b);
        chk({tag, "_s100"}, stock_100, c);
    endtask

    function automatic int first(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    initial begin
        int t;
        int low;
        int n;

        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_notes", {note_500, note_200, note_100}, 0);
        chk("rst_done_err", {dispense_done, dispense_error}, 0);
        chk_stock("rst", 0, 0, 0);
        rst = 1'b1;

        // 800 -> one of each note, N=3
        do_refill(10, 10, 10);
        #1 chk_stock("refill1", 10, 10, 10);
        do_req(800, t);
        low = 0;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (!req_ready) low++;
        end
        chk("800_ready_low_cycles", low, 13);
        wait_end("800");
        chk("800_n500_cyc", first(q500) - t, 8);
        chk("800_n200_cyc", first(q200) - t, 10);
        chk("800_n100_cyc", first(q100) - t, 12);
        chk("800_done_cyc", first(qdone) - t, 14);
        chk("800_counts", (q500.size() << 8) | (q200.size() << 4) | q100.size(), 32'h111);
        chk("800_no_err", qerr.size(), 0);
        chk("800_stock_at_pulse", s500_at_pulse, 9);
        chk("800_ready_at_done", rdy_at_end, 1);
        chk_stock("800", 9, 9, 9);

        // 150 -> plans one 100, leftover 50
        do_req(150, t);
        wait_end("150");
        chk("150_err_cyc", first(qerr) - t, 6);
        chk("150_ready_at_err", rdy_at_end, 1);
        chk("150_notes", q500.size() + q200.size() + q100.size(), 0);
        chk_stock("150", 9, 9, 9);

        // 600 with 1/3/0 -> greedy dead end
        do_refill(1, 3, 0);
        do_req(600, t);
        wait_end("600");
        chk("600_err_cyc", first(qerr) - t, 6);
        chk("600_notes", q500.size() + q200.size() + q100.size(), 0);
        chk_stock("600", 1, 3, 0);

        do_req(0, t);
        wait_end("zero");
        chk("zero_err_cyc", first(qerr) - t, 5);
        chk("zero_no_done", qdone.size(), 0);
        chk("zero_notes", q500.size() + q200.size() + q100.size(), 0);

        // refill and request together: refill wins
        clear_log();
        @(negedge clk);
        refill = 1'b1; refill_500 = 10'd5; refill_200 = 10'd5; refill_100 = 10'd5;
        req_valid = 1'b1; req_amount = 20'd100;
        #1 chk("both_ready_low", req_ready, 0);
        @(posedge clk);
        #1 refill = 1'b0; req_valid = 1'b0;
        chk_stock("both", 5, 5, 5);
        repeat (8) @(negedge clk);
        chk("both_no_activity", q100.size() + qdone.size() + qerr.size(), 0);
        chk("both_idle", req_ready, 1);

        // 700 with refill attempted during dispense
        do_req(700, t);
        n = 0;
        while (q500.size() == 0 && n < 100) begin @(negedge clk); #1; n++; end
        refill = 1'b1; refill_500 = '0; refill_200 = '0; refill_100 = '0;
        @(negedge clk);
        refill = 1'b0;
        wait_end("700");
        chk("700_n500_cyc", first(q500) - t, 7);
        chk("700_n200_cyc", first(q200) - t, 9);
        chk("700_done_cyc", first(qdone) - t, 11);
        chk_stock("700", 4, 4, 5);

        // reset in the middle of dispensing 1000
        do_req(1000, t);
        n = 0;
        while (q500.size() == 0 && n < 100) begin @(negedge clk); #1; n++; end
        chk("1000_first_cyc", first(q500) - t, 7);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_notes", {note_500, note_200, note_100}, 0);
        chk("arst_done_err", {dispense_done, dispense_error}, 0);
        chk_stock("arst", 0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("arst_no_more_pulses", q500.size(), 1);
        chk("arst_no_done", qdone.size() + qerr.size(), 0);
        chk("arst_ready", req_ready, 1);
        chk_stock("post_rst", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
